rf_writeback_arbiter: RTL and testbench

- Sequences the register file's single write port between NREQ writeback requesters: index 0 ALU, 1 load unit, 2 UART debug writer.
- Keeps a per-register pending-write scoreboard so the decode stage can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file.
- Emits one registered write pulse per accepted request.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_writeback_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/rf_writeback_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, requester indices and write-path state type for the register-file
// writeback arbiter.
package rf_pkg;

    localparam int unsigned DEF_NREQ  = 3;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_DW    = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_DBG = 2;

    typedef enum logic {
        StIdle,
        StWrite
    } wr_state_e;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of writeback requests, decode-side hazard queries and the register-file write port.
interface rf_writeback_arbiter_if #(
    parameter int unsigned NREQ  = rf_pkg::DEF_NREQ,
    parameter int unsigned NREGS = rf_pkg::DEF_NREGS,
    parameter int unsigned AW    = rf_pkg::DEF_AW,
    parameter int unsigned DW    = rf_pkg::DEF_DW
) ();

    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ*AW-1:0] i_req_rd;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]    o_req_ready;
    logic               i_issue_valid;
    logic [AW-1:0]      i_issue_rd;
    logic               o_issue_ready;
    logic [AW-1:0]      i_rs1;
    logic [AW-1:0]      i_rs2;
    logic               o_rs1_busy;
    logic               o_rs2_busy;
    logic               i_flush;
    logic               o_wr_en;
    logic [AW-1:0]      o_wr_addr;
    logic [DW-1:0]      o_wr_data;
    logic [NREGS-1:0]   o_busy_vec;

    modport slave (
        input  i_req_valid, i_req_rd, i_req_data, i_issue_valid, i_issue_rd,
        input  i_rs1, i_rs2, i_flush,
        output o_req_ready, o_issue_ready, o_rs1_busy, o_rs2_busy,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy_vec
    );

    modport master (
        output i_req_valid, i_req_rd, i_req_data, i_issue_valid, i_issue_rd,
        output i_rs1, i_rs2, i_flush,
        input  o_req_ready, o_issue_ready, o_rs1_busy, o_rs2_busy,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy_vec
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from a pointer that moves
// past the winner whenever a grant is given.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        if (advance_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = PtrW'((32'(ptr_q) + i) % N);
                if (!found && req_i[idx]) begin
                    found        = 1'b1;
                    grant_o[idx] = 1'b1;
                    ptr_d        = (32'(idx) == N - 1) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: round-robin shares the single write port, registers the
// write, and tracks pending writers per register for RAW/WAW stalls in decode.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input logic                   clk,
    input logic                   rst,
    rf_writeback_arbiter_if.slave bus
);

    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ready;
    logic             xfer;
    logic [AW-1:0]    sel_rd;
    logic [DW-1:0]    sel_data;
    logic             wr_ok;
    logic             issue_ready;
    logic             issue_set;

    wr_state_e        state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [NREGS-1:0] busy_q, busy_d;

    // Register 0 and addresses past the file never take part in writes or hazards.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    function automatic logic busy_at(input logic [NREGS-1:0] vec, input logic [AW-1:0] a);
        return in_range(a) && vec[a];
    endfunction

    rr_arbiter #(
        .N(NREQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.i_req_valid),
        .advance_i(!bus.i_flush),
        .grant_o  (grant)
    );

    assign ready = grant & {NREQ{rst}};

    always_comb begin
        xfer     = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                xfer     = 1'b1;
                sel_rd   = bus.i_req_rd[i*AW +: AW];
                sel_data = bus.i_req_data[i*DW +: DW];
            end
        end
    end

    assign wr_ok       = xfer && in_range(sel_rd);
    assign issue_ready = !bus.i_flush && !busy_at(busy_q, bus.i_issue_rd);
    assign issue_set   = bus.i_issue_valid && issue_ready && in_range(bus.i_issue_rd);

    always_comb begin
        state_d   = StIdle;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle:  state_d = wr_ok ? StWrite : StIdle;
            StWrite: state_d = wr_ok ? StWrite : StIdle;
        endcase
        if (wr_ok) begin
            wr_addr_d = sel_rd;
            wr_data_d = sel_data;
        end
    end

    // Clear before set so a new writer issued on the commit edge stays pending.
    always_comb begin
        busy_d = busy_q;
        if (bus.i_flush) begin
            busy_d = '0;
        end else begin
            if (wr_ok) begin
                busy_d[sel_rd] = 1'b0;
            end
            if (issue_set) begin
                busy_d[bus.i_issue_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_req_ready   = ready;
    assign bus.o_issue_ready = issue_ready;
    assign bus.o_rs1_busy    = busy_at(busy_q, bus.i_rs1);
    assign bus.o_rs2_busy    = busy_at(busy_q, bus.i_rs2);
    assign bus.o_wr_en       = (state_q == StWrite);
    assign bus.o_wr_addr     = wr_addr_q;
    assign bus.o_wr_data     = wr_data_q;
    assign bus.o_busy_vec    = busy_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: directed stimulus queues expected writes,
// a negedge monitor pops them as o_wr_en pulses appear.
module tb_rf_writeback_arbiter;
    import rf_pkg::*;

    localparam int unsigned NREQ  = DEF_NREQ;
    localparam int unsigned NREGS = DEF_NREGS;
    localparam int unsigned AW    = DEF_AW;
    localparam int unsigned DW    = DEF_DW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_arbiter_if #(
        .NREQ (NREQ),
        .NREGS(NREGS),
        .AW   (AW),
        .DW   (DW)
    ) bus ();

    rf_writeback_arbiter #(
        .NREQ (NREQ),
        .NREGS(NREGS),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int unsigned idx, input logic v, input logic [AW-1:0] rd,
                           input logic [DW-1:0] data);
        bus.i_req_valid[idx]          = v;
        bus.i_req_rd[idx*AW +: AW]    = rd;
        bus.i_req_data[idx*DW +: DW]  = data;
    endtask

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && bus.o_wr_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         bus.o_wr_addr, bus.o_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_wr_addr", 64'(bus.o_wr_addr), 64'(e.addr));
                check("sb_wr_data", 64'(bus.o_wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        logic [NREQ-1:0] cgnt[4];
        logic [AW-1:0]   caddr[4];
        cgnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
        caddr = '{5'd1, 5'd2, 5'd3, 5'd1};

        bus.i_req_valid   = '0;
        bus.i_req_rd      = '0;
        bus.i_req_data    = '0;
        bus.i_issue_valid = 1'b0;
        bus.i_issue_rd    = '0;
        bus.i_rs1         = '0;
        bus.i_rs2         = '0;
        bus.i_flush       = 1'b0;

        // Reset: ready must stay low even with a valid request.
        #1 rst = 1'b0;
        set_req(REQ_ALU, 1'b1, 5'd5, 32'h1234);
        settle();
        check("rst_ready", 64'(bus.o_req_ready), 64'b0);
        check("rst_wr_en", 64'(bus.o_wr_en), 64'b0);
        check("rst_wr_addr", 64'(bus.o_wr_addr), 64'b0);
        check("rst_wr_data", 64'(bus.o_wr_data), 64'b0);
        check("rst_busy_vec", 64'(bus.o_busy_vec), 64'b0);
        bus.i_req_valid = '0;
        repeat (2) tick();
        rst = 1'b1;

        // Single ALU request.
        set_req(REQ_ALU, 1'b1, 5'd5, 32'h1234);
        settle();
        check("single_ready", 64'(bus.o_req_ready), 64'b001);
        expect_wr(5'd5, 32'h1234);
        tick();
        set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
        settle();
        check("single_wr_en", 64'(bus.o_wr_en), 64'b1);
        check("single_wr_addr", 64'(bus.o_wr_addr), 64'd5);
        tick();
        check("single_wr_en_pulse", 64'(bus.o_wr_en), 64'b0);

        // rd=0 from the debug writer: accepted, no write; pointer wraps to 0.
        set_req(REQ_DBG, 1'b1, 5'd0, 32'hDEAD);
        settle();
        check("rz_ready", 64'(bus.o_req_ready), 64'b100);
        tick();
        set_req(REQ_DBG, 1'b0, 5'd0, 32'h0);
        settle();
        check("rz_wr_en", 64'(bus.o_wr_en), 64'b0);
        check("rz_busy_vec", 64'(bus.o_busy_vec), 64'b0);

        // Contention: all three valid, grants rotate 0,1,2,0.
        set_req(REQ_ALU, 1'b1, 5'd1, 32'hA1);
        set_req(REQ_LSU, 1'b1, 5'd2, 32'hA2);
        set_req(REQ_DBG, 1'b1, 5'd3, 32'hA3);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("cont_ready_%0d", k), 64'(bus.o_req_ready), 64'(cgnt[k]));
            expect_wr(caddr[k], 32'hA0 + 32'(caddr[k]));
            tick();
        end
        bus.i_req_valid = '0;
        settle();
        check("cont_last_wr_en", 64'(bus.o_wr_en), 64'b1);

        // Scoreboard set, WAW block, clear on commit.
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd7;
        bus.i_rs1         = 5'd7;
        bus.i_rs2         = 5'd7;
        settle();
        check("sb_issue_ready", 64'(bus.o_issue_ready), 64'b1);
        check("sb_rs1_idle", 64'(bus.o_rs1_busy), 64'b0);
        tick();
        bus.i_issue_valid = 1'b0;
        settle();
        check("sb_busy7", 64'(bus.o_busy_vec), 64'(32'h1 << 7));
        check("sb_rs1_busy", 64'(bus.o_rs1_busy), 64'b1);
        check("sb_rs2_busy", 64'(bus.o_rs2_busy), 64'b1);
        bus.i_issue_valid = 1'b1;
        settle();
        check("sb_waw_block", 64'(bus.o_issue_ready), 64'b0);
        tick();
        bus.i_issue_valid = 1'b0;
        set_req(REQ_LSU, 1'b1, 5'd7, 32'h77);
        settle();
        check("sb_lsu_ready", 64'(bus.o_req_ready), 64'b010);
        check("sb_busy7_hold", 64'(bus.o_busy_vec), 64'(32'h1 << 7));
        expect_wr(5'd7, 32'h77);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        settle();
        check("sb_busy7_clear", 64'(bus.o_busy_vec), 64'b0);
        check("sb_rs1_clear", 64'(bus.o_rs1_busy), 64'b0);

        // Same-edge commit and issue on rd=9: set wins.
        set_req(REQ_ALU, 1'b1, 5'd9, 32'h99);
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd9;
        settle();
        check("se_ready", 64'(bus.o_req_ready), 64'b001);
        check("se_issue_ready", 64'(bus.o_issue_ready), 64'b1);
        expect_wr(5'd9, 32'h99);
        tick();
        set_req(REQ_ALU, 1'b0, 5'd0, 32'h0);
        bus.i_issue_valid = 1'b0;
        settle();
        check("se_busy9", 64'(bus.o_busy_vec), 64'(32'h1 << 9));
        set_req(REQ_LSU, 1'b1, 5'd9, 32'h9A);
        settle();
        check("se_lsu_ready", 64'(bus.o_req_ready), 64'b010);
        expect_wr(5'd9, 32'h9A);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        settle();
        check("se_busy9_clear", 64'(bus.o_busy_vec), 64'b0);

        // Issue to register 0 never marks busy.
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd0;
        bus.i_rs1         = 5'd0;
        settle();
        check("z_issue_ready", 64'(bus.o_issue_ready), 64'b1);
        tick();
        bus.i_issue_valid = 1'b0;
        settle();
        check("z_busy_vec", 64'(bus.o_busy_vec), 64'b0);
        check("z_rs1_busy", 64'(bus.o_rs1_busy), 64'b0);

        // Flush with pending rd=3/4 and a captured write to 12.
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd3;
        tick();
        bus.i_issue_rd    = 5'd4;
        tick();
        bus.i_issue_valid = 1'b0;
        settle();
        check("fl_busy34", 64'(bus.o_busy_vec), 64'((32'h1 << 3) | (32'h1 << 4)));
        set_req(REQ_DBG, 1'b1, 5'd12, 32'hC0FFEE);
        settle();
        check("fl_dbg_ready", 64'(bus.o_req_ready), 64'b100);
        expect_wr(5'd12, 32'hC0FFEE);
        tick();
        set_req(REQ_ALU, 1'b1, 5'd1, 32'hA1);
        set_req(REQ_LSU, 1'b1, 5'd2, 32'hA2);
        set_req(REQ_DBG, 1'b1, 5'd3, 32'hA3);
        bus.i_flush       = 1'b1;
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd5;
        settle();
        check("fl_ready", 64'(bus.o_req_ready), 64'b0);
        check("fl_issue_ready", 64'(bus.o_issue_ready), 64'b0);
        check("fl_wr_en", 64'(bus.o_wr_en), 64'b1);
        check("fl_wr_addr", 64'(bus.o_wr_addr), 64'd12);
        tick();
        check("fl_busy_clear", 64'(bus.o_busy_vec), 64'b0);
        check("fl_wr_en_after", 64'(bus.o_wr_en), 64'b0);
        bus.i_flush       = 1'b0;
        bus.i_issue_valid = 1'b0;
        settle();
        check("fl_resume_ready", 64'(bus.o_req_ready), 64'b001);
        expect_wr(5'd1, 32'hA1);
        tick();
        bus.i_req_valid = '0;
        settle();

        // Reset in the middle of a write discards it and rewinds the pointer.
        set_req(REQ_LSU, 1'b1, 5'd20, 32'hDEAD);
        settle();
        check("mr_ready", 64'(bus.o_req_ready), 64'b010);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        settle();
        check("mr_wr_en", 64'(bus.o_wr_en), 64'b0);
        check("mr_wr_addr", 64'(bus.o_wr_addr), 64'b0);
        check("mr_wr_data", 64'(bus.o_wr_data), 64'b0);
        tick();
        rst = 1'b1;
        set_req(REQ_LSU, 1'b1, 5'd21, 32'hB1);
        set_req(REQ_DBG, 1'b1, 5'd22, 32'hB2);
        settle();
        check("mr_ptr_reset", 64'(bus.o_req_ready), 64'b010);
        expect_wr(5'd21, 32'hB1);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 32'h0);
        settle();
        check("mr_next_ready", 64'(bus.o_req_ready), 64'b100);
        expect_wr(5'd22, 32'hB2);
        tick();
        set_req(REQ_DBG, 1'b0, 5'd0, 32'h0);
        repeat (3) tick();
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
